// File: rtl/n_bit_isqrt_pkg.sv
// Shared definitions for the iterative integer square root: FSM states and counter sizing.
package n_bit_isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: clog2(n), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEFAULT_N  = 8;
    localparam int unsigned DEFAULT_CW = cnt_width(DEFAULT_N);

endpackage

// File: rtl/n_bit_isqrt_step.sv
// One restoring digit-recurrence step of the square root: brings in a radicand bit pair, yields one root bit.
module isqrt_step #(
    parameter int unsigned N = 8
) (
    input  logic [N+1:0] rem,
    input  logic [N-1:0] root,
    input  logic [1:0]   pair,
    output logic [N+1:0] rem_next_c,
    output logic [N-1:0] root_next_c
);

    localparam int unsigned RW = N + 2;

    logic [RW-1:0] shifted_c;
    logic [RW-1:0] trial_c;
    logic          fits_c;

    always_comb begin
        shifted_c   = RW'({rem, pair});
        trial_c     = {root, 2'b01};
        fits_c      = (shifted_c >= trial_c);
        rem_next_c  = fits_c ? (shifted_c - trial_c) : shifted_c;
        root_next_c = N'({root, fits_c});
    end

endmodule

// File: rtl/n_bit_isqrt.sv
// Sequential integer square root: one root bit per clock, N busy cycles per radicand.
module n_bit_isqrt
    import n_bit_isqrt_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] radicand,
    output logic [N-1:0]   root,
    output logic [N:0]     remainder,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = cnt_width(N);
    localparam int unsigned RW = N + 2;
    localparam int unsigned DW = 2 * N;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  rad;
    logic [RW-1:0]  rem_q;
    logic [N-1:0]   root_q;
    logic [RW-1:0]  rem_nx_c;
    logic [N-1:0]   root_nx_c;
    logic           load_c;
    logic           step_c;

    isqrt_step #(.N(N)) u_step (
        .rem         (rem_q),
        .root        (root_q),
        .pair        (rad[DW-1 -: 2]),
        .rem_next_c  (rem_nx_c),
        .root_next_c (root_nx_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Start is honoured from IDLE and DONE only, so DONE can chain straight into BUSY.
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        step_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                step_c = 1'b1;
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load_c   = 1'b1;
                    state_nx = BUSY;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rad    <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else if (load_c) begin
            cnt    <= CW'(N - 1);
            rad    <= radicand;
            rem_q  <= '0;
            root_q <= '0;
        end else if (step_c) begin
            cnt    <= cnt - CW'(1);
            rad    <= rad << 2;
            rem_q  <= rem_nx_c;
            root_q <= root_nx_c;
        end
    end

    // Final remainder never exceeds 2*root, so the top datapath bit is always zero here.
    assign root      = root_q;
    assign remainder = rem_q[N:0];
    assign busy      = (state == BUSY);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_n_bit_isqrt.sv
// Directed and randomized checks of the sequential square root at N=8.
module tb_n_bit_isqrt;

    localparam int unsigned N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N-1:0] radicand;
    logic [N-1:0]   root;
    logic [N:0]     remainder;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_fails  = 0;

    n_bit_isqrt #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .radicand  (radicand),
        .root      (root),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a radicand with start for one edge; returns sampling just after the accepting edge.
    task automatic start_op(input logic [2*N-1:0] r);
        radicand = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Count edges and busy samples until done, bounded so a stuck DUT still ends the run.
    task automatic wait_done(input int lat0, input int b0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = b0 + (busy ? 1 : 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
    endtask

    int lat;
    int bcnt;
    int dpulses;
    logic [31:0] r32;
    logic [31:0] q32;
    logic [31:0] m32;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        radicand = '0;
        #1;
        check("reset_root", 32'(root), 32'd0);
        check("reset_rem",  32'(remainder), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Zero radicand and single-cycle done pulse.
        start_op(16'd0);
        wait_done(0, 0, lat, bcnt);
        check("zero_latency", 32'(lat), 32'd8);
        check("zero_busy_cycles", 32'(bcnt), 32'd8);
        check("zero_root", 32'(root), 32'd0);
        check("zero_rem",  32'(remainder), 32'd0);
        tick();
        check("zero_done_one_cycle", 32'(done), 32'd0);
        check("zero_back_to_idle", 32'(busy), 32'd0);
        tick();

        // Back-to-back: 200 then 64 with start held during DONE.
        start_op(16'd200);
        wait_done(0, 0, lat, bcnt);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_root", 32'(root), 32'd14);
        check("b2b_first_rem",  32'(remainder), 32'd4);
        start_op(16'd64);
        check("b2b_no_idle_gap", 32'(busy), 32'd1);
        wait_done(0, 0, lat, bcnt);
        check("b2b_second_latency", 32'(lat), 32'd8);
        check("b2b_second_root", 32'(root), 32'd8);
        check("b2b_second_rem",  32'(remainder), 32'd0);
        tick();

        // Upper boundary.
        start_op(16'd65535);
        wait_done(0, 0, lat, bcnt);
        check("max_latency", 32'(lat), 32'd8);
        check("max_root", 32'(root), 32'd255);
        check("max_rem",  32'(remainder), 32'd510);
        tick();

        // Start during the third BUSY cycle must be ignored.
        start_op(16'd1000);
        tick();
        tick();
        radicand = 16'd9;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(3, 3, lat, bcnt);
        check("ignore_latency", 32'(lat), 32'd8);
        check("ignore_busy_cycles", 32'(bcnt), 32'd8);
        check("ignore_root", 32'(root), 32'd31);
        check("ignore_rem",  32'(remainder), 32'd39);
        tick();

        // Reset in the fourth BUSY cycle aborts with no done pulse.
        start_op(16'd50);
        tick();
        tick();
        tick();
        check("abort_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy_async", 32'(busy), 32'd0);
        check("abort_root", 32'(root), 32'd0);
        check("abort_rem",  32'(remainder), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        dpulses = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done) dpulses++;
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) dpulses++;
        end
        check("abort_no_done", 32'(dpulses), 32'd0);
        start_op(16'd50);
        wait_done(0, 0, lat, bcnt);
        check("after_abort_latency", 32'(lat), 32'd8);
        check("after_abort_root", 32'(root), 32'd7);
        check("after_abort_rem",  32'(remainder), 32'd1);
        tick();

        // Randomized radicands against the square-root identities.
        for (int i = 0; i < 12; i++) begin
            r32 = 32'($urandom_range(0, 65535));
            start_op(16'(r32));
            wait_done(0, 0, lat, bcnt);
            q32 = 32'(root);
            m32 = 32'(remainder);
            check("rand_busy_cycles", 32'(bcnt), 32'd8);
            check("rand_identity", q32 * q32 + m32, r32);
            check("rand_rem_bound", 32'(m32 <= 2 * q32), 32'd1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/n_bit_isqrt.md
N_BIT_ISQRT -- requirements
Module: n_bit_isqrt

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the root width in bits; the radicand is 2N bits.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a computation, sampled at the clk rising edge.
REQ-005 The module SHALL have port radicand, input, 2N bits: unsigned value to root, captured on an accepted start.
REQ-006 The module SHALL have port root, output, N bits: floor(sqrt(radicand)).
REQ-007 The module SHALL have port remainder, output, N+1 bits: radicand minus root squared.
REQ-008 The module SHALL have port busy, output, 1 bit: high while iterating.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking root and remainder valid.

Function
REQ-010 FSM SHALL have three states, IDLE, BUSY and DONE, with IDLE as the reset state.
REQ-011 start SHALL be accepted only in IDLE or DONE; on acceptance the FSM SHALL capture radicand, clear the partial root and remainder, load iteration counter = N-1, and enter BUSY.
REQ-012 start SHALL be ignored while in BUSY: no restart, and the captured radicand SHALL be unchanged.
REQ-013 Each BUSY cycle SHALL perform one restoring digit-recurrence step: shift the next two radicand bits (MSB pair first) into the remainder, trial = (root<<2)|1 aligned to the remainder, and on remainder >= trial subtract and shift in root bit 1, else shift in root bit 0.
REQ-014 Each BUSY cycle SHALL decrement the counter; the FSM SHALL leave BUSY for DONE on the step with counter = 0, giving exactly N BUSY cycles.
REQ-015 Latency SHALL be as follows: with start accepted at edge E, done SHALL be high for exactly the cycle following edge E+N.
REQ-016 DONE SHALL last one cycle; the FSM SHALL then go to IDLE, or to BUSY if start is high in that cycle (back-to-back, no idle gap).
REQ-017 root and remainder SHALL hold their final values from DONE until the next accepted start; they need not be meaningful during BUSY.
REQ-018 busy SHALL equal (state == BUSY), and done SHALL equal (state == DONE), both decoded from registered state.
REQ-019 The internal remainder datapath SHALL be N+2 bits wide to hold the trial compare without overflow; the output remainder SHALL be truncated to N+1 bits, which is lossless since the remainder is at most 2*root.
REQ-020 For all inputs the outputs SHALL satisfy root*root + remainder == radicand and remainder <= 2*root.

Reset
REQ-021 While rst is high the FSM SHALL be forced to IDLE asynchronously, independent of clk.
REQ-022 While rst is high root, remainder, counter and captured radicand SHALL be forced to 0, and busy and done SHALL be 0.
REQ-023 A reset asserted mid-BUSY SHALL abort the computation with no done pulse; the first start after rst deasserts SHALL run a full N-cycle computation.

Structure
REQ-024 A shared package SHALL hold the state enumeration (IDLE, BUSY, DONE) and a counter-width constant, clog2(N) with a minimum of 1.
REQ-025 One combinational sub-module, isqrt_step, SHALL be used; it takes the current remainder, root and two-bit radicand pair, and returns the next remainder and next root.
REQ-026 The top-level SHALL contain only the FSM, the counter and the registers.

Verification (N=8)
REQ-027 The bench SHALL apply radicand=0 with start; required response: done at start edge+8, root=0, remainder=0.
REQ-028 The bench SHALL apply radicand=200 and then radicand=64 back-to-back, with start held in the DONE cycle; required response: root=14 and remainder=4, then root=8 and remainder=0, with no idle cycle between them.
REQ-029 The bench SHALL apply radicand=65535; required response: root=255, remainder=510 (upper-boundary width check).
REQ-030 The bench SHALL apply radicand=1000, then pulse start with radicand=9 at the 3rd BUSY cycle; required response: the second start is ignored, root=31, remainder=39.
REQ-031 The bench SHALL apply radicand=50 and assert rst at the 4th BUSY cycle; required response: outputs go to 0 immediately, no done pulse, and a following start with radicand=50 gives root=7, remainder=1.
REQ-032 The bench SHALL apply randomized radicands; required response: the REQ-020 identities hold, and busy stays high for exactly 8 cycles per run.
